// File: rtl/func_code_capture.sv
// rtl/func_code_capture.sv - debounced capture of function code and interface select
//
// Purpose: synchronizes the raw switches, confirm button and clear request,
// debounces the confirm button, and on a confirmed press latches the switch
// code (a, b, c) and interface select (d) for the downstream router. An
// optional hold timer returns the outputs to the cleared code.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   sw[2:0]        raw function-code switches (sw[0]->a, sw[1]->b, sw[2]->c)
//   sel_sw         raw interface-select switch (->d)
//   btn_ok         raw confirm button, active-high
//   clr            raw clear request, level, active-high
//   a, b, c, d     registered code and select to the router
//   valid          high while a captured code is held
//   load_pulse     one-cycle pulse when a new code is loaded
//   timeout_pulse  one-cycle pulse when the hold timer clears the code

module func_code_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  input  logic       sel_sw,
  input  logic       btn_ok,
  input  logic       clr,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       valid,
  output logic       load_pulse,
  output logic       timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    RELEASE_WAIT = 2'd2
  } state_e;

  localparam logic [15:0] DEB_TARGET = 16'(DEBOUNCE_CYCLES);
  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] HOLD_LAST  = 24'(HOLD_CYCLES - 1);
  localparam bit          HOLD_EN    = (HOLD_CYCLES != 0);

  // Two-flop synchronizers; *_meta_q is the first stage.
  logic [2:0] sw_meta_q, sw_s;
  logic       sel_meta_q, sel_s;
  logic       btn_meta_q, btn_s;
  logic       clr_meta_q, clr_s;

  state_e      state_q, state_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic [23:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]  code_q, code_d;      // {d, c, b, a}
  logic        valid_q, valid_d;
  logic        load_q, load_d;
  logic        tmo_q, tmo_d;
  logic        accept;

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    code_d     = code_q;
    valid_d    = valid_q;
    load_d     = 1'b0;
    tmo_d      = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = 16'd1;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          // Glitch: drop back without touching the outputs.
          state_d   = IDLE;
          deb_cnt_d = 16'd0;
        end else if (deb_cnt_q >= DEB_TARGET) begin
          accept = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 16'd1;
        end
      end
      RELEASE_WAIT: begin
        // Only a full run of low samples re-arms; a held button never retriggers.
        if (btn_s) begin
          deb_cnt_d = 16'd0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = 16'd0;
        end else begin
          deb_cnt_d = deb_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = 16'd0;
      end
    endcase

    // Hold timer: outputs stay valid for exactly HOLD_CYCLES edges after a load.
    if (HOLD_EN && valid_q) begin
      if (hold_cnt_q == HOLD_LAST) begin
        code_d     = 4'd0;
        valid_d    = 1'b0;
        tmo_d      = 1'b1;
        hold_cnt_d = 24'd0;
      end else begin
        hold_cnt_d = hold_cnt_q + 24'd1;
      end
    end

    // Accept overrides a coincident timeout.
    if (accept) begin
      code_d     = {sel_s, sw_s};
      valid_d    = 1'b1;
      load_d     = 1'b1;
      tmo_d      = 1'b0;
      hold_cnt_d = 24'd0;
      deb_cnt_d  = 16'd0;
      state_d    = RELEASE_WAIT;
    end

    // Clear overrides everything; parking in RELEASE_WAIT blocks re-capture of a held button.
    if (clr_s) begin
      code_d     = 4'd0;
      valid_d    = 1'b0;
      load_d     = 1'b0;
      tmo_d      = 1'b0;
      hold_cnt_d = 24'd0;
      deb_cnt_d  = 16'd0;
      state_d    = RELEASE_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q  <= 3'd0;
      sw_s       <= 3'd0;
      sel_meta_q <= 1'b0;
      sel_s      <= 1'b0;
      btn_meta_q <= 1'b0;
      btn_s      <= 1'b0;
      clr_meta_q <= 1'b0;
      clr_s      <= 1'b0;
      state_q    <= IDLE;
      deb_cnt_q  <= 16'd0;
      hold_cnt_q <= 24'd0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      load_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      sw_meta_q  <= sw;
      sw_s       <= sw_meta_q;
      sel_meta_q <= sel_sw;
      sel_s      <= sel_meta_q;
      btn_meta_q <= btn_ok;
      btn_s      <= btn_meta_q;
      clr_meta_q <= clr;
      clr_s      <= clr_meta_q;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      load_q     <= load_d;
      tmo_q      <= tmo_d;
    end
  end

  assign a             = code_q[0];
  assign b             = code_q[1];
  assign c             = code_q[2];
  assign d             = code_q[3];
  assign valid         = valid_q;
  assign load_pulse    = load_q;
  assign timeout_pulse = tmo_q;

endmodule
